ram_sync: RTL and testbench
===========================

// Module: ram_sync
// PURPOSE
//  Single-port synchronous RAM: one shared address, one write port, one registered read port.
//  Working storage for the parallel adder/accumulator datapath; holds wide operand/result vectors.
//  Infers block RAM; the storage array is never reset, only the output register is.
// PARAMETERS
//  ADDR_WIDTH  6    address bits; depth = 2**ADDR_WIDTH words (64)
//  DATA_WIDTH  512  word width in bits; must be a multiple of 8
// PORTS
//  clk           in   1                 clock; all state changes on rising edge
//  rst           in   1                 reset: synchronous, active-high
//  addr          in   ADDR_WIDTH        word address for both read and write
//  write_enable  in   1                 1 = write data_in to mem[addr] this edge
//  data_in       in   DATA_WIDTH        write data
//  byte_en       in   DATA_WIDTH/8      per-byte write mask (only with RAM_BYTE_WE_EN)
//  data_out      out  DATA_WIDTH        registered read data
// BEHAVIOUR
//  - Reset: on a rising edge with rst=1, data_out <= 0 and no write occurs, even if write_enable=1.
//    Memory contents are unchanged by reset.
//  - Write: on a rising edge with rst=0 and write_enable=1, mem[addr] <= data_in.
//  - Read: on every rising edge with rst=0, data_out <= mem[addr]. Latency is 1 cycle;
//    data_out holds its value between edges.
//  - Collision (write_enable=1): write-first. data_out <= new word, i.e. the word as stored
//    after the write (data_in, or the merged word with byte enables).
//  - Address: full range 0..2**ADDR_WIDTH-1 is valid, with no wrap or aliasing.
//    Narrower values driven on data_in are zero-extended by the driver.
//  - Unwritten locations: contents undefined (X in simulation). No init file.
//  - Reset is released mid-stream: the first edge with rst=0 performs a normal access.
// CONFIGURATION
//  RAM_BYTE_WE_EN defined:
//    - byte_en port exists.
//    - On a write, byte lane i (bits 8i+7:8i) is updated only if byte_en[i]=1; other lanes keep old data.
//    - write_enable=1 with byte_en=0 stores nothing; data_out still returns the current word.
//  RAM_BYTE_WE_EN undefined:
//    - No byte_en port.
//    - Every write updates the full word.
// TESTING
//  1. rst=1 for 2 edges with we=1, addr=0, din=0xaa -> data_out=0; a later read of addr 0 does not return 0xaa from that write.
//  2. Write addr0=0xaa, then addr1=0x55, then we=0:
//     - read addr1 -> 0x55 one edge later
//     - read addr0 -> 0xaa
//     - read addr1 -> 0x55
//  3. Overwrite addr1 with 0x2a, then we=0 -> read addr1 = 0x2a.
//     Same edge as the write, data_out already = 0x2a (write-first).
//  4. Write addr63 with all-ones and addr0 with 0 -> addr63 reads all-ones and addr0 reads 0 (no aliasing).
//  5. Back-to-back reads of addr0, 1, 0 on consecutive edges -> data_out follows with exactly 1-cycle lag.
//  6. (RAM_BYTE_WE_EN) addr2 = all-ones; write din=0 with byte_en=...0001 -> addr2 reads all-ones except bits 7:0 = 0x00.

Source files
------------

// File: rtl/ram_sync.sv
// Single-port synchronous RAM with write-first registered read; only the output register is reset.
// Optional per-byte write mask enabled by defining RAM_BYTE_WE_EN (adds the byte_en port).
module ram_sync #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    write_enable,
`ifdef RAM_BYTE_WE_EN
  input  logic [DATA_WIDTH/8-1:0] byte_en,
`endif
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned NLANE = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  w_wr;

  // Reset suppresses writes but never clears the array.
  assign w_wr = write_enable && !rst;

`ifdef RAM_BYTE_WE_EN
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int unsigned i = 0; i < NLANE; i++) begin
        if (byte_en[i]) r_mem[addr][i*8 +: 8] <= data_in[i*8 +: 8];
      end
    end
  end

  // Write-first: each lane returns new data if written this edge, else the stored byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out <= '0;
    end else begin
      for (int unsigned i = 0; i < NLANE; i++) begin
        if (write_enable && byte_en[i]) r_data_out[i*8 +: 8] <= data_in[i*8 +: 8];
        else                            r_data_out[i*8 +: 8] <= r_mem[addr][i*8 +: 8];
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[addr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst)               r_data_out <= '0;
    else if (write_enable) r_data_out <= data_in;
    else                   r_data_out <= r_mem[addr];
  end
`endif

  assign data_out = r_data_out;

endmodule

// File: tb/tb_ram_sync.sv
// Directed self-checking bench for ram_sync (write-first, 1-cycle read latency, sync reset).
module tb_ram_sync;
  localparam int AW = 6;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic          write_enable;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
`ifdef RAM_BYTE_WE_EN
  logic [DW/8-1:0] byte_en;
`endif

  int tests = 0;
  int fails = 0;

  ram_sync #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .write_enable (write_enable),
`ifdef RAM_BYTE_WE_EN
    .byte_en      (byte_en),
`endif
    .data_in      (data_in),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] exp);
    tests++;
    assert (data_out === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, data_out, exp);
    end
  endtask

  logic [DW-1:0] ones;
  logic [DW-1:0] exp_v;

  initial begin
    ones = '1;
    rst = 1'b1; write_enable = 1'b1; addr = '0; data_in = DW'(8'haa);
`ifdef RAM_BYTE_WE_EN
    byte_en = '1;
`endif
    tick(); check("reset_edge1", '0);
    tick(); check("reset_edge2", '0);

    // The write attempted during reset must not have landed.
    rst = 1'b0; write_enable = 1'b0; addr = '0;
    tick();
    tests++;
    assert (data_out !== DW'(8'haa))
    else begin
      fails++;
      $error("FAIL reset_no_write: got %h expected not %h", data_out, DW'(8'haa));
    end

    write_enable = 1'b1; addr = 6'd0; data_in = DW'(8'haa);
    tick(); check("wr0_first", DW'(8'haa));
    addr = 6'd1; data_in = DW'(8'h55);
    tick(); check("wr1_first", DW'(8'h55));
    write_enable = 1'b0; addr = 6'd1;
    tick(); check("rd1_a", DW'(8'h55));
    addr = 6'd0;
    tick(); check("rd0", DW'(8'haa));
    addr = 6'd1;
    tick(); check("rd1_b", DW'(8'h55));

    write_enable = 1'b1; addr = 6'd1; data_in = DW'(8'h2a);
    tick(); check("ovw1_first", DW'(8'h2a));
    write_enable = 1'b0;
    tick(); check("ovw1_read", DW'(8'h2a));

    write_enable = 1'b1; addr = 6'd63; data_in = ones;
    tick(); check("wr63_first", ones);
    addr = 6'd0; data_in = '0;
    tick(); check("wr0_zero", '0);
    write_enable = 1'b0; addr = 6'd63;
    tick(); check("rd63", ones);
    addr = 6'd0;
    tick(); check("rd0_zero", '0);
    addr = 6'd1;
    tick(); check("rd1_intact", DW'(8'h2a));

    // Back-to-back reads 0,1,0 with the output held between edges.
    addr = 6'd0;
    tick(); check("b2b_0", '0);
    addr = 6'd1;
    #2; check("b2b_hold", '0);
    tick(); check("b2b_1", DW'(8'h2a));
    addr = 6'd0;
    tick(); check("b2b_0b", '0);

    // Mid-stream reset clears output, blocks write, and releases into a normal read.
    addr = 6'd1;
    tick(); check("pre_rst", DW'(8'h2a));
    rst = 1'b1; write_enable = 1'b1; data_in = DW'(16'h1234);
    tick(); check("mid_rst", '0);
    rst = 1'b0; write_enable = 1'b0;
    tick(); check("post_rst", DW'(8'h2a));

`ifdef RAM_BYTE_WE_EN
    write_enable = 1'b1; addr = 6'd2; data_in = ones; byte_en = '1;
    tick(); check("be_full", ones);
    data_in = '0; byte_en = '0; byte_en[0] = 1'b1;
    exp_v = {{(DW-8){1'b1}}, 8'h00};
    tick(); check("be_lane0_first", exp_v);
    write_enable = 1'b0;
    tick(); check("be_lane0_read", exp_v);
    write_enable = 1'b1; byte_en = '0;
    tick(); check("be_none", exp_v);
    write_enable = 1'b0;
    tick(); check("be_none_read", exp_v);
`else
    write_enable = 1'b1; addr = 6'd2; data_in = DW'(16'h1234);
    tick(); check("full_wr2", DW'(16'h1234));
    write_enable = 1'b0;
    exp_v = DW'(16'h1234);
    tick(); check("full_rd2", exp_v);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
